// File: rtl/formula_cex_scanner.sv
// Sweeps assignments into a combinational formula through a registered bus.
// Every assignment that drives o_1 low is handed off as a counterexample over a valid/ready port.
module formula_cex_scanner #(
  parameter int          NUM_VARS  = 61,
  parameter int          CNT_W     = 32,
  parameter logic [67:0] LFSR_TAPS = 68'h1000000000000000B,
  parameter logic [67:0] LFSR_SEED = 68'd1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [CNT_W-1:0]    max_vec,
  input  logic                stop_on_cex,
  output logic [NUM_VARS-1:0] vec_o,
  input  logic                formula_o,
  output logic                cex_valid,
  input  logic                cex_ready,
  output logic [NUM_VARS-1:0] cex_vec,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    vec_count,
  output logic [CNT_W-1:0]    cex_count
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one vector tested per cycle
  // HOLD  | counterexample presented, waiting for handshake
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [NUM_VARS-1:0] TAPS     = LFSR_TAPS[NUM_VARS-1:0];
  localparam logic [NUM_VARS-1:0] SEED_RAW = LFSR_SEED[NUM_VARS-1:0];
  localparam logic [NUM_VARS-1:0] SEED     = (SEED_RAW == '0) ? NUM_VARS'(1) : SEED_RAW;

  state_t state, state_nxt;

  logic                mode_q;
  logic                stop_q;
  logic [CNT_W-1:0]    max_q;
  logic [NUM_VARS-1:0] vec_nxt;
  logic [CNT_W-1:0]    vec_count_inc;
  logic                last_vec;
  logic                sweep_end;
  logic                handshake;

  assign vec_count_inc = vec_count + CNT_W'(1);
  assign last_vec      = (vec_count_inc == max_q);
  assign handshake     = cex_valid & cex_ready;
  // in HOLD vec_count already includes the failing vector
  assign sweep_end     = stop_q | (vec_count == max_q);

  always_comb begin
    vec_nxt = vec_o + NUM_VARS'(1);
    if (mode_q) begin
      vec_nxt = (vec_o >> 1) ^ (vec_o[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (max_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!formula_o) begin
          state_nxt = HOLD;
        end else if (last_vec) begin
          state_nxt = DONE;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_nxt = sweep_end ? DONE : RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, HOLD: busy = 1'b1;
      DONE:      done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_o     <= '0;
      cex_vec   <= '0;
      cex_valid <= 1'b0;
      vec_count <= '0;
      cex_count <= '0;
      mode_q    <= 1'b0;
      stop_q    <= 1'b0;
      max_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            stop_q    <= stop_on_cex;
            max_q     <= max_vec;
            vec_count <= '0;
            cex_count <= '0;
            if (max_vec != '0) begin
              vec_o <= mode ? SEED : '0;
            end
          end
        end
        RUN: begin
          vec_count <= vec_count_inc;
          if (!formula_o) begin
            cex_vec   <= vec_o;
            cex_valid <= 1'b1;
          end else if (!last_vec) begin
            vec_o <= vec_nxt;
          end
        end
        HOLD: begin
          if (handshake) begin
            cex_valid <= 1'b0;
            if (cex_count != '1) begin
              cex_count <= cex_count + CNT_W'(1);
            end
            if (!sweep_end) begin
              vec_o <= vec_nxt;
            end
          end
        end
        default: begin
          cex_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
